// File: rtl/dme_pkg.sv
// Shared DME definitions: FSM state encoding, reusable by the receiver, and the
// jitter LFSR constants and step function.
package dme_pkg;

  typedef enum logic [2:0] {
    DME_IDLE   = 3'd0,
    DME_DELAY  = 3'd1,
    DME_RISE   = 3'd2,
    DME_HOLD   = 3'd3,
    DME_FALL   = 3'd4,
    DME_GAP    = 3'd5,
    DME_LISTEN = 3'd6
  } dme_state_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DELAY  = 3'd1;
  localparam logic [2:0] ST_RISE   = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_FALL   = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;
  localparam logic [2:0] ST_LISTEN = 3'd6;

  // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register: bits 0,2,3,5
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/dme_pulse_shaper.sv
// Single-pulse amplitude generator: saturating ramp up to PEAK, HOLD cycles at
// PEAK, saturating ramp down to BASE. phase_o is the phase of the sample on amp_o.
module dme_pulse_shaper
  import dme_pkg::*;
#(
  parameter int unsigned       WIDTH = 12,
  parameter logic [WIDTH-1:0]  BASE  = 12'd0,
  parameter logic [WIDTH-1:0]  PEAK  = 12'd2000,
  parameter logic [WIDTH-1:0]  STEP  = 12'd250,
  parameter int unsigned       HOLD  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  output logic [WIDTH-1:0] amp_o,
  output logic             busy_o,
  output logic             pulse_done_o,
  output logic [2:0]       phase_o
);

  logic [2:0]       phase_q, phase_d;
  logic [WIDTH-1:0] amp_q, amp_d;
  logic [31:0]      hold_q, hold_d;
  logic [WIDTH:0]   sum_w, span_w;
  logic [WIDTH-1:0] up_w, dn_w;

  // One extra bit so amp+STEP cannot wrap before the PEAK clamp
  always_comb begin
    sum_w  = {1'b0, amp_q} + {1'b0, STEP};
    up_w   = (sum_w >= {1'b0, PEAK}) ? PEAK : sum_w[WIDTH-1:0];
    span_w = {1'b0, amp_q} - {1'b0, BASE};
    dn_w   = (span_w <= {1'b0, STEP}) ? BASE : (amp_q - STEP);
  end

  always_comb begin
    phase_d = phase_q;
    amp_d   = amp_q;
    hold_d  = hold_q;
    case (phase_q)
      ST_IDLE: begin
        if (start_i) begin
          amp_d   = up_w;
          phase_d = ST_RISE;
        end
      end
      ST_RISE: begin
        if (amp_q == PEAK) begin
          phase_d = ST_HOLD;
          hold_d  = '0;
        end else begin
          amp_d = up_w;
        end
      end
      ST_HOLD: begin
        if (hold_q + 32'd1 >= HOLD) begin
          phase_d = ST_FALL;
          amp_d   = dn_w;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      ST_FALL: begin
        if (amp_q == BASE) begin
          phase_d = ST_IDLE;
        end else begin
          amp_d = dn_w;
        end
      end
      default: begin
        phase_d = ST_IDLE;
        amp_d   = BASE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= ST_IDLE;
      amp_q   <= BASE;
      hold_q  <= '0;
    end else begin
      phase_q <= phase_d;
      amp_q   <= amp_d;
      hold_q  <= hold_d;
    end
  end

  assign amp_o        = amp_q;
  assign busy_o       = (phase_q != ST_IDLE);
  assign pulse_done_o = (phase_q == ST_FALL) && (amp_q == BASE);
  assign phase_o      = phase_q;

endmodule

// File: rtl/dme_pulse_tx.sv
// DME interrogator transmitter: pulse burst, spacing and reply-window FSM.
// Define DME_TX_JITTER_EN to add an LFSR-driven trigger-to-burst delay.
module dme_pulse_tx
  import dme_pkg::*;
#(
  parameter int unsigned       WIDTH    = 12,
  parameter logic [WIDTH-1:0]  BASE     = 12'd0,
  parameter logic [WIDTH-1:0]  PEAK     = 12'd2000,
  parameter logic [WIDTH-1:0]  STEP     = 12'd250,
  parameter int unsigned       HOLD     = 8,
  parameter int unsigned       SPACING  = 120,
  parameter int unsigned       NPULSE   = 2,
  parameter int unsigned       WINDOW   = 32'd4000,
  parameter int unsigned       JIT_BITS = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             trigger,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             timer_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [2:0]       dbg_state
);

  // Handshake: go_w is a one-cycle start strobe, issued only while the shaper
  // is idle; the shaper raises busy on the same edge and pulse_done marks the
  // cycle showing the final BASE sample of the pulse.
  logic [2:0]       state_q, state_d;
  logic [31:0]      spc_q, spc_d;
  logic [31:0]      np_q, np_d;
  logic [31:0]      win_q, win_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             go_w;
  logic [WIDTH-1:0] shp_amp;
  logic             shp_busy, shp_done;
  logic [2:0]       shp_phase;

`ifdef DME_TX_JITTER_EN
  logic [15:0]         lfsr_q;
  logic [JIT_BITS-1:0] dly_q, dly_d;
`endif

  always_comb begin
    state_d   = state_q;
    spc_d     = spc_q;
    np_d      = np_q;
    win_d     = win_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    go_w      = 1'b0;
`ifdef DME_TX_JITTER_EN
    dly_d     = dly_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
`ifdef DME_TX_JITTER_EN
          if (lfsr_q[JIT_BITS-1:0] == '0) begin
            go_w = 1'b1;
          end else begin
            state_d = ST_DELAY;
            dly_d   = lfsr_q[JIT_BITS-1:0] - 1'b1;
          end
`else
          go_w = 1'b1;
`endif
        end
      end
`ifdef DME_TX_JITTER_EN
      ST_DELAY: begin
        if (dly_q == '0) go_w = 1'b1;
        else             dly_d = dly_q - 1'b1;
      end
`endif
      // ST_RISE here covers the whole pulse; the shaper tracks RISE/HOLD/FALL
      ST_RISE: begin
        spc_d = spc_q + 32'd1;
        if (shp_done) begin
          if (np_q < NPULSE) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_LISTEN;
            win_d   = '0;
          end
        end
      end
      ST_GAP: begin
        spc_d = spc_q + 32'd1;
        if (spc_q + 32'd1 >= SPACING) go_w = 1'b1;
      end
      ST_LISTEN: begin
        if (rx_valid) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (win_q + 32'd1 >= WINDOW) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          win_d = win_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (go_w) begin
      state_d = ST_RISE;
      spc_d   = '0;
      np_d    = (state_q == ST_GAP) ? (np_q + 32'd1) : 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      spc_q     <= '0;
      np_q      <= '0;
      win_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      spc_q     <= spc_d;
      np_q      <= np_d;
      win_q     <= win_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef DME_TX_JITTER_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= LFSR_SEED;
      dly_q  <= '0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      dly_q  <= dly_d;
    end
  end
`endif

  dme_pulse_shaper #(
    .WIDTH (WIDTH),
    .BASE  (BASE),
    .PEAK  (PEAK),
    .STEP  (STEP),
    .HOLD  (HOLD)
  ) u_shaper (
    .clk_i        (clk),
    .rst_ni       (resetn),
    .start_i      (go_w),
    .amp_o        (shp_amp),
    .busy_o       (shp_busy),
    .pulse_done_o (shp_done),
    .phase_o      (shp_phase)
  );

  assign out_data  = shp_amp;
  assign busy      = (state_q != ST_IDLE);
  assign timer_en  = (state_q == ST_RISE) || (state_q == ST_GAP) || (state_q == ST_LISTEN);
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign dbg_state = shp_busy ? shp_phase : state_q;

endmodule

// File: tb/tb_dme_pulse_tx.sv
// Directed bench for dme_pulse_tx: a default-parameter unit and a STEP=300,
// single-pulse, short-window unit driven from one linear sequence.
module tb_dme_pulse_tx;

  logic        clk;
  logic        resetn;
  logic        trig_a, rxv_a, ten_a, busy_a, done_a, to_a;
  logic [11:0] out_a;
  logic [2:0]  st_a;
  logic        trig_b, rxv_b, ten_b, busy_b, done_b, to_b;
  logic [11:0] out_b;
  logic [2:0]  st_b;

  int checks   = 0;
  int failures = 0;

  int exp_b_tbl [16] = '{300, 600, 900, 1200, 1500, 1800, 2000, 2000, 2000,
                         1700, 1400, 1100, 800, 500, 200, 0};

  dme_pulse_tx u_dut_a (
    .clk       (clk),
    .resetn    (resetn),
    .trigger   (trig_a),
    .rx_valid  (rxv_a),
    .out_data  (out_a),
    .timer_en  (ten_a),
    .busy      (busy_a),
    .done      (done_a),
    .timeout   (to_a),
    .dbg_state (st_a)
  );

  dme_pulse_tx #(
    .STEP   (12'd300),
    .HOLD   (2),
    .NPULSE (1),
    .WINDOW (32'd16)
  ) u_dut_b (
    .clk       (clk),
    .resetn    (resetn),
    .trigger   (trig_b),
    .rx_valid  (rxv_b),
    .out_data  (out_b),
    .timer_en  (ten_b),
    .busy      (busy_b),
    .done      (done_b),
    .timeout   (to_b),
    .dbg_state (st_b)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DME_TX_JITTER_EN
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Passes the trigger edge and any jitter delay; returns on the first RISE sample
  task automatic launch(input bit use_b);
    int j;
    j = 0;
`ifdef DME_TX_JITTER_EN
    j = int'(m_lfsr[3:0]);
`endif
    step();
    for (int d = 0; d < j; d++) begin
      chk("dly_busy", use_b ? busy_b : busy_a, 32'd1);
      chk("dly_timer_en", use_b ? ten_b : ten_a, 32'd0);
      chk("dly_out", use_b ? out_b : out_a, 32'd0);
      step();
    end
  endtask

  function automatic int exp_a(input int i);
    int j;
    j = (i >= 120) ? i - 120 : i;
    if (j < 8)  return 250 * (j + 1);
    if (j < 16) return 2000;
    if (j < 24) return 2000 - 250 * (j - 15);
    return 0;
  endfunction

  initial begin
    resetn = 1'b0;
    trig_a = 1'b0; rxv_a = 1'b0;
    trig_b = 1'b0; rxv_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_busy_a", busy_a, 32'd0);
    chk("rst_ten_a", ten_a, 32'd0);
    chk("rst_done_a", done_a, 32'd0);
    chk("rst_timeout_a", to_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    resetn = 1'b1;
    step();
    step();
    chk("idle_busy_a", busy_a, 32'd0);

    // Burst 1: trigger held high throughout, rx_valid in a GAP and 50 cycles into LISTEN
    trig_a = 1'b1;
    launch(1'b0);
    for (int i = 0; i < 195; i++) begin
      chk("a_out", out_a, exp_a(i));
      chk("a_timer_en", ten_a, 32'd1);
      chk("a_busy", busy_a, 32'd1);
      chk("a_done_low", done_a, 32'd0);
      rxv_a = (i == 60) || (i == 194);
      step();
    end
    rxv_a = 1'b0;
    chk("rx_done", done_a, 32'd1);
    chk("rx_no_timeout", to_a, 32'd0);
    chk("rx_busy_drop", busy_a, 32'd0);
    chk("rx_ten_drop", ten_a, 32'd0);
    chk("rx_out_base", out_a, 32'd0);

    // Held trigger starts the next burst on the edge after busy fell
    launch(1'b0);
    chk("retrig_out", out_a, 32'd250);
    chk("retrig_busy", busy_a, 32'd1);
    chk("retrig_done_clear", done_a, 32'd0);
    trig_a = 1'b0;

    // Same burst runs to window expiry: LISTEN at cycle 144, timeout 4000 later
    repeat (4143) step();
    chk("pre_timeout_busy", busy_a, 32'd1);
    chk("pre_timeout_low", to_a, 32'd0);
    step();
    chk("timeout_pulse", to_a, 32'd1);
    chk("timeout_no_done", done_a, 32'd0);
    chk("timeout_busy_drop", busy_a, 32'd0);
    chk("timeout_ten_drop", ten_a, 32'd0);
    step();
    chk("timeout_one_cycle", to_a, 32'd0);

    // Burst: rx_valid on the last window cycle -> done wins
    trig_a = 1'b1;
    launch(1'b0);
    trig_a = 1'b0;
    repeat (4143) step();
    rxv_a = 1'b1;
    step();
    rxv_a = 1'b0;
    chk("tie_done", done_a, 32'd1);
    chk("tie_no_timeout", to_a, 32'd0);
    chk("tie_busy_drop", busy_a, 32'd0);
    step();
    chk("tie_done_one_cycle", done_a, 32'd0);

    // Burst: asynchronous reset in HOLD
    trig_a = 1'b1;
    launch(1'b0);
    trig_a = 1'b0;
    repeat (10) step();
    chk("hold_out", out_a, 32'd2000);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_out", out_a, 32'd0);
    chk("async_rst_ten", ten_a, 32'd0);
    chk("async_rst_busy", busy_a, 32'd0);
    chk("async_rst_state", st_a, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (30) step();
    chk("no_resume_out", out_a, 32'd0);
    chk("no_resume_busy", busy_a, 32'd0);

    // Unit B: STEP=300 ramps, HOLD=2, one pulse, WINDOW=16
    trig_b = 1'b1;
    launch(1'b1);
    trig_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("b_out", out_b, exp_b_tbl[i]);
      chk("b_timer_en", ten_b, 32'd1);
      step();
    end
    chk("b_listen_state", st_b, 32'd6);
    chk("b_listen_out", out_b, 32'd0);
    chk("b_listen_ten", ten_b, 32'd1);
    repeat (15) step();
    chk("b_pre_timeout", to_b, 32'd0);
    chk("b_pre_timeout_busy", busy_b, 32'd1);
    step();
    chk("b_timeout", to_b, 32'd1);
    chk("b_timeout_no_done", done_b, 32'd0);
    chk("b_busy_drop", busy_b, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dme_pulse_tx.md
# dme_pulse_tx

Interrogator-side transmitter for the DME ranging chain. On a trigger it emits a shaped pulse burst (default: one X-mode pulse pair) as a WIDTH-bit sample stream toward the DAC/channel model. It holds `timer_en` high from the first transmitted sample, which drives the peak-timing `receiver`'s `start`. It then listens until the receiver reports `valid` or a reply window expires.

## Interface
- `WIDTH`, 12: sample width
- `BASE`, 12'd0: idle/baseline sample value
- `PEAK`, 12'd2000: pulse top amplitude; must satisfy BASE < PEAK < 2^WIDTH
- `STEP`, 12'd250: amplitude change per cycle on ramps; must be ≥ 1
- `HOLD`, 8: cycles at PEAK per pulse; must be ≥ 1
- `SPACING`, 120: leading-edge to leading-edge pulse spacing, in cycles
- `NPULSE`, 2: pulses per burst; must be ≥ 1
- `WINDOW`, 32'd4000: listen cycles after the last pulse before timeout
- `JIT_BITS`, 4: jitter delay width (used only under the macro)
- `clk`  in  1: clock, rising edge
- `resetn`  in  1: asynchronous active-low reset
- `trigger`  in  1: start-burst request; level sampled in IDLE only
- `rx_valid`  in  1: reply detected, from `receiver.valid`
- `out_data`  out  WIDTH: transmitted sample, registered
- `timer_en`  out  1: ranging timer enable, goes to `receiver.start`
- `busy`  out  1: high in every state except IDLE
- `done`  out  1: one-cycle pulse; reply received
- `timeout`  out  1: one-cycle pulse; window expired without a reply

## Operation
- States: IDLE, DELAY (macro only), RISE, HOLD, FALL, GAP, LISTEN.
- IDLE, `trigger`=1 → RISE. `trigger` in any other state is ignored.
- RISE: amp ← min(amp+STEP, PEAK). Compute in WIDTH+1 bits so the sum cannot wrap. When the new value equals PEAK, go to HOLD.
- HOLD: stay exactly HOLD cycles, then go to FALL.
- FALL: amp ← max(amp−STEP, BASE), saturating. When the new value equals BASE:
  - if pulses sent < NPULSE → GAP;
  - else → LISTEN.
- Spacing counter: zeroed on the first RISE cycle of each pulse.
  - GAP → RISE when the counter reaches SPACING−1.
  - If SPACING ≤ pulse length, GAP lasts exactly one cycle (the next pulse starts immediately).
- LISTEN: window counter starts at 0. Exit conditions:
  - `rx_valid`=1 → pulse `done`, go to IDLE;
  - counter reaches WINDOW−1 → pulse `timeout`, go to IDLE;
  - both in the same cycle → `done` wins, `timeout` stays 0.
- `rx_valid` outside LISTEN is ignored.
- `timer_en` = 1 from the first RISE cycle through the last LISTEN cycle, continuous across GAPs.
- Reset values: `out_data`=BASE; `timer_en`, `busy`, `done`, `timeout` = 0; state IDLE; all counters 0.
- Reset asserted mid-burst returns every output to its reset value immediately (asynchronous). No partial burst resumes after reset.

## Timing
- Trigger sampled at edge k (no jitter): after edge k, `out_data`=BASE+STEP and `busy`=`timer_en`=1.
- Rise and fall each last ceil((PEAK−BASE)/STEP) cycles. One pulse lasts 2·ceil((PEAK−BASE)/STEP) + HOLD cycles.
- The final FALL cycle outputs BASE.
- `done`/`timeout` are high for the cycle IDLE is entered; `busy` and `timer_en` drop on that same edge.
- A new `trigger` is accepted on the edge after `busy` falls.

## Configuration
- `DME_TX_JITTER_EN` defined:
  - a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reset to the seed) advances every cycle;
  - on trigger, the block enters DELAY for J = LFSR[JIT_BITS-1:0] cycles with `busy`=1, `timer_en`=0, `out_data`=BASE;
  - J=0 goes straight to RISE.
- `DME_TX_JITTER_EN` undefined: no LFSR and no DELAY state; latency is exactly as given in Timing.

## Structure
- `dme_pkg`: state enum, LFSR polynomial taps and seed constant; `receiver` can reuse the state enum.
- Sub-module `dme_pulse_shaper`: saturating ramp/hold amplitude generator (start/busy handshake, PEAK/STEP/HOLD, outputs amp and pulse_done).
- The top level owns the burst/spacing/listen FSM and the jitter logic.

## Test plan
- Defaults, trigger once → `out_data` 0,250,…,2000 over 8 cycles, 8 cycles at 2000, falls to 0 over 8 cycles; second pulse leading edge exactly 120 cycles after the first; `timer_en` high throughout.
- STEP=300 → rise sequence 300,…,1800,2000 with no overshoot; fall sequence 1700,…,200,0.
- `rx_valid` pulsed 50 cycles into LISTEN → one-cycle `done`; `timer_en` and `busy` drop on that edge; `timeout` stays 0.
- No `rx_valid` → `timeout` pulses exactly WINDOW cycles after LISTEN entry; `rx_valid` and window expiry in the same cycle → `done` only.
- `trigger` held high for an entire burst → exactly one burst; the next burst starts on the edge after `busy` falls.
- `resetn` low during HOLD → `out_data`=0 and `timer_en`=0 without waiting for a clock edge. With `DME_TX_JITTER_EN`, trigger-to-RISE delay equals LFSR[3:0], checked against a reference model.
